// File: rtl/d_cell_cache_if.sv
// Bundle between the core, the single-cell cache and the data memory port.
// The cache is the slave side; the core plus memory together form the master side.
interface d_cell_cache_if #(
  parameter int d_addr_width = 8
);
  // Core-facing operation channel
  logic                    op_valid;
  logic [2:0]              op;
  logic [7:0]              op_data;
  logic                    op_ready;
  logic [7:0]              cell_val;
  logic                    cell_zero;
  logic [d_addr_width-1:0] dptr;

  // Data memory channel
  logic                    d_req;
  logic                    d_dir;
  logic [d_addr_width-1:0] d_addr;
  logic [7:0]              d_wdata;
  logic                    d_ack;
  logic [7:0]              d_rdata;

  modport master (
    output op_valid, op, op_data, d_ack, d_rdata,
    input  op_ready, cell_val, cell_zero, dptr, d_req, d_dir, d_addr, d_wdata
  );

  modport slave (
    input  op_valid, op, op_data, d_ack, d_rdata,
    output op_ready, cell_val, cell_zero, dptr, d_req, d_dir, d_addr, d_wdata
  );
endinterface

// File: rtl/d_cell_cache.sv
// Single-cell write-back cache plus data pointer. Arithmetic and PUT ops hit the
// cached cell in one cycle; pointer moves write back a dirty cell, leave one idle
// request cycle, then fetch the newly addressed cell.
module d_cell_cache #(
  parameter int d_addr_width = 8,
  parameter int d_mem_length = 64
) (
  input  logic           clk,
  input  logic           rst,
  d_cell_cache_if.slave  bus
);

  // Shared memory-direction encoding
  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  localparam logic [d_addr_width-1:0] PTR_LAST = d_addr_width'(d_mem_length - 1);
  localparam logic [d_addr_width-1:0] PTR_ONE  = d_addr_width'(1);

  typedef enum logic [1:0] {
    S_READY,
    S_WB,
    S_GAP,
    S_RD
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_DEC   = 3'd2,
    OP_RIGHT = 3'd3,
    OP_LEFT  = 3'd4,
    OP_PUT   = 3'd5,
    OP_FLUSH = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  state_t                  state;
  state_t                  state_next;
  op_t                     op_code;
  logic [d_addr_width-1:0] dptr;
  logic [d_addr_width-1:0] wb_addr;
  logic [d_addr_width-1:0] ptr_right;
  logic [d_addr_width-1:0] ptr_left;
  logic [7:0]              cell_val;
  logic                    dirty;
  logic                    flush_only;

  assign op_code   = op_t'(bus.op);
  assign ptr_right = (dptr == PTR_LAST) ? '0 : dptr + PTR_ONE;
  assign ptr_left  = (dptr == '0) ? PTR_LAST : dptr - PTR_ONE;

  assign bus.cell_val  = cell_val;
  assign bus.cell_zero = (cell_val == 8'h00);
  assign bus.dptr      = dptr;

  // State register; reset always restarts with a fetch of cell 0
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (rst) begin
      state <= S_RD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      S_READY: begin
        if (bus.op_valid) begin
          case (op_code)
            OP_RIGHT, OP_LEFT: state_next = dirty ? S_WB : S_RD;
            OP_FLUSH:          if (dirty) state_next = S_WB;
            default:           state_next = S_READY;
          endcase
        end
      end
      S_WB:  if (bus.d_ack) state_next = S_GAP;
      S_GAP: state_next = flush_only ? S_READY : S_RD;
      S_RD:  if (bus.d_ack) state_next = S_READY;
    endcase
  end

  // Moore outputs; requests are masked while reset is held so an abandoned
  // transaction is never seen by the memory
  always_comb begin
    bus.op_ready = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_dir    = DIRECTION_READ;
    bus.d_addr   = dptr;
    bus.d_wdata  = 8'h00;
    unique case (state)
      S_READY: bus.op_ready = 1'b1;
      S_WB: begin
        bus.d_req   = ~rst;
        bus.d_dir   = DIRECTION_WRITE;
        bus.d_addr  = wb_addr;
        bus.d_wdata = cell_val;
      end
      S_GAP: bus.d_req = 1'b0;
      S_RD:  bus.d_req = ~rst;
    endcase
  end

  // Pointer, cached cell and dirty tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      dptr       <= '0;
      wb_addr    <= '0;
      cell_val   <= 8'h00;
      dirty      <= 1'b0;
      flush_only <= 1'b0;
    end else begin
      unique case (state)
        S_READY: begin
          if (bus.op_valid) begin
            case (op_code)
              OP_INC: begin
                cell_val <= cell_val + 8'd1;
                dirty    <= 1'b1;
              end
              OP_DEC: begin
                cell_val <= cell_val - 8'd1;
                dirty    <= 1'b1;
              end
              OP_PUT: begin
                cell_val <= bus.op_data;
                dirty    <= 1'b1;
              end
              OP_RIGHT: begin
                wb_addr    <= dptr;
                dptr       <= ptr_right;
                flush_only <= 1'b0;
              end
              OP_LEFT: begin
                wb_addr    <= dptr;
                dptr       <= ptr_left;
                flush_only <= 1'b0;
              end
              OP_FLUSH: begin
                wb_addr    <= dptr;
                flush_only <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_WB: begin
          if (bus.d_ack) dirty <= 1'b0;
        end
        S_RD: begin
          if (bus.d_ack) begin
            cell_val <= bus.d_rdata;
            dirty    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_cell_cache.sv
// Directed bench for d_cell_cache: a memory model with programmable write-ack
// delay, a cell/pointer/memory-image reference model, and a per-cycle compare.
module tb_d_cell_cache;

  localparam int   AW        = 8;
  localparam int   LEN       = 64;
  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  d_cell_cache_if #(.d_addr_width(AW)) bus ();

  d_cell_cache #(.d_addr_width(AW), .d_mem_length(LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] init_val(input int i);
    if (i == 0 || i == LEN - 1) return 8'h00;
    return 8'(i * 3 + 7);
  endfunction

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  logic       mem_ack   = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  bit         loaded    = 1'b0;
  int         wr_delay  = 0;
  int         wait_cnt  = 0;
  logic       log_dir  [$];
  logic [7:0] log_addr [$];
  logic [7:0] log_data [$];

  assign bus.d_ack   = mem_ack;
  assign bus.d_rdata = mem_rdata;

  // Memory: preload once, then ack each request after its delay
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end
    if (bus.d_req !== 1'b1 || mem_ack) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (wait_cnt >= ((bus.d_dir == DIR_WRITE) ? wr_delay : 0)) begin
      mem_ack <= 1'b1;
      log_dir.push_back(bus.d_dir);
      log_addr.push_back(bus.d_addr);
      if (bus.d_dir == DIR_WRITE) begin
        mem[bus.d_addr] <= bus.d_wdata;
        log_data.push_back(bus.d_wdata);
      end else begin
        mem_rdata <= mem[bus.d_addr];
        log_data.push_back(mem[bus.d_addr]);
      end
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] model_mem [256];
  logic [7:0] model_cell  = 8'h00;
  int         model_ptr   = 0;
  bit         model_dirty = 1'b0;

  task automatic model_reset();
    model_ptr   = 0;
    model_dirty = 1'b0;
    model_cell  = model_mem[0];
  endtask

  task automatic model_apply(input logic [2:0] o, input logic [7:0] d);
    case (o)
      3'd1: begin model_cell = model_cell + 8'd1; model_dirty = 1'b1; end
      3'd2: begin model_cell = model_cell - 8'd1; model_dirty = 1'b1; end
      3'd5: begin model_cell = d;                 model_dirty = 1'b1; end
      3'd3, 3'd4: begin
        if (model_dirty) model_mem[model_ptr] = model_cell;
        model_ptr   = (o == 3'd3) ? (model_ptr + 1) % LEN : (model_ptr + LEN - 1) % LEN;
        model_cell  = model_mem[model_ptr];
        model_dirty = 1'b0;
      end
      3'd6: begin
        if (model_dirty) model_mem[model_ptr] = model_cell;
        model_dirty = 1'b0;
      end
      default: ;
    endcase
  endtask

  // ---------------- per-cycle compare ----------------
  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic       prev_dir = 1'b0;
  logic [7:0] prev_addr  = 8'h00;
  logic [7:0] prev_wdata = 8'h00;

  // Compare outputs against the model and check request-phase stability
  always @(negedge clk) begin
    if (rst) begin
      prev_req <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      if (bus.op_ready === 1'b1) begin
        check("cell_val", bus.cell_val, model_cell);
        check("cell_zero", bus.cell_zero, model_cell == 8'h00);
        check("dptr", bus.dptr, model_ptr);
      end
      if (prev_ack) begin
        check("req_low_after_ack", bus.d_req, 1'b0);
      end else if (prev_req) begin
        check("req_held", bus.d_req, 1'b1);
        check("dir_held", bus.d_dir, prev_dir);
        check("addr_held", bus.d_addr, prev_addr);
        check("wdata_held", bus.d_wdata, prev_wdata);
      end
      prev_req   <= bus.d_req;
      prev_ack   <= bus.d_ack;
      prev_dir   <= bus.d_dir;
      prev_addr  <= bus.d_addr;
      prev_wdata <= bus.d_wdata;
    end
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  task automatic wait_ready(output int n);
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.op_ready !== 1'b1) check("ready_timeout", bus.op_ready, 1'b1);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] d, input bit wait_done,
                       output int lat);
    int n;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.op_data  = d;
    wait_ready(n);
    @(posedge clk);
    model_apply(o, d);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    @(negedge clk);
    lat = 0;
    if (wait_done) begin
      wait_ready(n);
      lat = n + 1;
    end
  endtask

  task automatic check_entry(input string name, input int idx, input logic dir,
                             input logic [7:0] addr, input logic [7:0] data);
    check({name, "_dir"},  log_dir[idx],  dir);
    check({name, "_addr"}, log_addr[idx], addr);
    check({name, "_data"}, log_data[idx], data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int lat;
    int base;
    int bad;

    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    bus.op_data  = 8'h00;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);

    // Reset and initial fetch of cell 0
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_ready(n);
    check("reset_ready_cycle", n, 2);
    check("reset_cell_val", bus.cell_val, 8'h00);
    check("reset_cell_zero", bus.cell_zero, 1'b1);
    check("reset_dptr", bus.dptr, 8'd0);
    check("reset_log_size", log_dir.size(), 1);
    check_entry("reset_read", 0, DIR_READ, 8'd0, 8'h00);

    // INC x3 then dirty RIGHT
    for (int i = 0; i < 3; i++) begin
      do_op(3'd1, 8'h00, 1'b1, lat);
      check("inc_latency", lat, 1);
    end
    check("inc3_cell", bus.cell_val, 8'h03);
    base = log_dir.size();
    do_op(3'd3, 8'h00, 1'b1, lat);
    check("dirty_right_latency", lat, 6);
    check("dirty_right_log", log_dir.size() - base, 2);
    check_entry("dirty_right_wb", base, DIR_WRITE, 8'd0, 8'h03);
    check_entry("dirty_right_rd", base + 1, DIR_READ, 8'd1, 8'h0A);
    check("dirty_right_dptr", bus.dptr, 8'd1);

    // Clean LEFT back to 0, then clean LEFT wrapping to 63
    base = log_dir.size();
    do_op(3'd4, 8'h00, 1'b1, lat);
    check("clean_left_latency", lat, 3);
    check_entry("clean_left_rd", base, DIR_READ, 8'd0, 8'h03);
    base = log_dir.size();
    do_op(3'd4, 8'h00, 1'b1, lat);
    check("wrap_left_latency", lat, 3);
    check("wrap_left_log", log_dir.size() - base, 1);
    check_entry("wrap_left_rd", base, DIR_READ, 8'd63, 8'h00);
    check("wrap_left_dptr", bus.dptr, 8'd63);

    // DEC underflow, PUT, dirty FLUSH, then clean RIGHT wrapping to 0
    do_op(3'd2, 8'h00, 1'b1, lat);
    check("dec_wrap_cell", bus.cell_val, 8'hFF);
    check("dec_wrap_zero", bus.cell_zero, 1'b0);
    do_op(3'd5, 8'h41, 1'b1, lat);
    check("put_cell", bus.cell_val, 8'h41);
    base = log_dir.size();
    do_op(3'd6, 8'h00, 1'b1, lat);
    check("flush_latency", lat, 4);
    check("flush_log", log_dir.size() - base, 1);
    check_entry("flush_wb", base, DIR_WRITE, 8'd63, 8'h41);
    base = log_dir.size();
    do_op(3'd3, 8'h00, 1'b1, lat);
    check("wrap_right_latency", lat, 3);
    check("wrap_right_log", log_dir.size() - base, 1);
    check("wrap_right_dptr", bus.dptr, 8'd0);
    check("wrap_right_cell", bus.cell_val, 8'h03);

    // Write-back with a 3-cycle slower ack
    do_op(3'd1, 8'h00, 1'b1, lat);
    wr_delay = 3;
    base = log_dir.size();
    do_op(3'd3, 8'h00, 1'b1, lat);
    wr_delay = 0;
    check("slow_wb_latency", lat, 9);
    check_entry("slow_wb", base, DIR_WRITE, 8'd0, 8'h04);
    check_entry("slow_wb_rd", base + 1, DIR_READ, 8'd1, 8'h0A);

    // Reset in the middle of a dirty write-back
    do_op(3'd5, 8'h99, 1'b1, lat);
    wr_delay = 5;
    base = log_dir.size();
    do_op(3'd3, 8'h00, 1'b0, lat);
    check("mid_wb_req", bus.d_req, 1'b1);
    check("mid_wb_dir", bus.d_dir, DIR_WRITE);
    check("mid_wb_addr", bus.d_addr, 8'd1);
    check("mid_wb_wdata", bus.d_wdata, 8'h99);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req_low", bus.d_req, 1'b0);
    check("rst_dptr", bus.dptr, 8'd0);
    check("rst_op_ready", bus.op_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wr_delay = 0;
    model_mem[1] = 8'h0A;
    model_reset();
    wait_ready(n);
    check("rst_ready_cycle", n, 2);
    check("rst_log", log_dir.size() - base, 1);
    check_entry("rst_refetch", base, DIR_READ, 8'd0, 8'h04);
    check("rst_cell", bus.cell_val, 8'h04);

    // NOP, reserved opcode and clean FLUSH are single-cycle no-ops
    base = log_dir.size();
    do_op(3'd0, 8'h00, 1'b1, lat);
    check("nop_latency", lat, 1);
    do_op(3'd7, 8'h55, 1'b1, lat);
    check("op7_latency", lat, 1);
    do_op(3'd6, 8'h00, 1'b1, lat);
    check("clean_flush_latency", lat, 1);
    check("noop_log", log_dir.size() - base, 0);
    check("noop_cell", bus.cell_val, 8'h04);

    bad = 0;
    for (int i = 0; i < LEN; i++) if (mem[i] !== model_mem[i]) bad++;
    check("mem_image_mismatches", bad, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
